bus_trap_monitor: RTL
=====================

BUS_TRAP_MONITOR -- requirements
Module: bus_trap_monitor

Interface
REQ-001 SHALL have parameter SUCCESS_ADDR, default 16'h3469, opcode-fetch address that marks test pass.
REQ-002 SHALL have parameter TRAP_REPEAT, default 3, number of consecutive identical opcode-fetch addresses that constitutes a trap (legal range 2..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd100_000_000, bus-cycle limit; 0 disables timeout.
REQ-004 SHALL use one clock, i_clk; reset is asynchronous and active-low, i_reset_n.
REQ-005 i_clk  input  1  system clock.
REQ-006 i_reset_n  input  1  async active-low reset.
REQ-007 i_phi2  input  1  CPU phi2, synchronous to i_clk.
REQ-008 i_sync  input  1  CPU opcode-fetch indicator.
REQ-009 i_addr  input  16  CPU bus address.
REQ-010 o_done  output  1  run finished (pass, fail or timeout), sticky.
REQ-011 o_pass  output  1  trapped at SUCCESS_ADDR, sticky.
REQ-012 o_fail  output  1  trapped at any other address, sticky.
REQ-013 o_timeout  output  1  TIMEOUT_CYCLES reached without trap, sticky.
REQ-014 o_trap_pc  output  16  address of trap (or last fetch address on timeout).
REQ-015 o_instr_count  output  32  opcode fetches counted, saturating.

Function
REQ-016 Bus strobe SHALL be i_phi2 high while registered previous i_phi2 low; i_sync and i_addr sampled only on strobe cycles.
REQ-017 Fetch event SHALL be a strobe with i_sync=1.
REQ-018 FSM states SHALL be ARMED, RUN, PASS, FAIL, TIMEOUT; reset state ARMED.
REQ-019 ARMED: first fetch event loads last_pc=i_addr, repeat_cnt=1, instr_count=1, moves to RUN.
REQ-020 RUN fetch with i_addr==last_pc SHALL increment repeat_cnt; otherwise load last_pc=i_addr, repeat_cnt=1.
REQ-021 Non-fetch strobes SHALL neither reset nor advance repeat_cnt.
REQ-022 When a RUN fetch makes repeat_cnt equal TRAP_REPEAT, next state SHALL be PASS if i_addr==SUCCESS_ADDR else FAIL; o_trap_pc=i_addr.
REQ-023 Bus-cycle counter SHALL increment on every strobe in ARMED and RUN; when it reaches TIMEOUT_CYCLES (nonzero) in RUN or ARMED, next state TIMEOUT, o_trap_pc=last_pc.
REQ-024 Trap and timeout on the same strobe: trap SHALL win.
REQ-025 o_instr_count SHALL increment on each fetch event in RUN, saturating at 32'hFFFF_FFFF.
REQ-026 Outputs SHALL be registered; o_done/o_pass/o_fail/o_timeout assert on the i_clk edge that processes the deciding strobe (visible the following cycle).
REQ-027 o_done SHALL equal o_pass|o_fail|o_timeout; exactly one flag set once done.
REQ-028 PASS, FAIL, TIMEOUT SHALL be terminal; all counters and o_trap_pc frozen until reset.
REQ-029 repeat_cnt SHALL saturate at TRAP_REPEAT (no wrap).
REQ-030 i_phi2 held high SHALL produce only one strobe.

Reset
REQ-031 Asserting i_reset_n low at any time, including mid-run or in a terminal state, SHALL immediately force ARMED, all outputs 0, last_pc=0, counters 0.
REQ-032 After release, first strobe SHALL be handled per REQ-016 using the registered phi2 value cleared to 0 by reset.

Verification
REQ-033 Fetches at 0x0400,0x0402,0x3469,0x3469,0x3469 -> o_pass=1, o_done=1, o_trap_pc=16'h3469, o_instr_count=5.
REQ-034 Fetches at 0x1234 x3 interleaved with two non-sync strobes each -> o_fail=1, o_trap_pc=16'h1234, o_pass=0.
REQ-035 TIMEOUT_CYCLES=10, fetches at incrementing addresses every strobe -> o_timeout=1 after 10th strobe, o_trap_pc=address of 10th fetch.
REQ-036 TIMEOUT_CYCLES=6, fetches 0x0500,0x0600,0x0700,0x0700,0x0700 plus one non-sync strobe before the third 0x0700 (6th strobe) -> o_fail=1, o_timeout=0.
REQ-037 Reset asserted 2 strobes after o_pass -> all outputs 0 within same cycle; new trap at 0x2000 x3 -> o_fail=1.
REQ-038 i_phi2 held high 20 i_clk cycles with i_sync=1 -> exactly one fetch counted.

Source files
------------

// File: rtl/bus_trap_monitor.sv
// Watches a 6502-style bus and reports pass, fail or timeout once the CPU
// keeps fetching the same opcode address (a trap) or runs too long.
module bus_trap_monitor #(
    parameter logic [15:0] SUCCESS_ADDR   = 16'h3469,
    parameter int unsigned TRAP_REPEAT    = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_phi2,
    input  logic        i_sync,
    input  logic [15:0] i_addr,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_fail,
    output logic        o_timeout,
    output logic [15:0] o_trap_pc,
    output logic [31:0] o_instr_count
);

    typedef enum logic [2:0] {ARMED, RUN, PASS, FAIL, TIMEOUT} state_t;

    localparam logic [3:0] TRAP_LIMIT = 4'(TRAP_REPEAT);

    state_t      state, state_n;
    logic        phi2_q;
    logic [15:0] last_pc, last_pc_n;
    logic [3:0]  repeat_cnt, repeat_cnt_n;
    logic [31:0] bus_cnt, bus_cnt_n;
    logic [31:0] instr_cnt, instr_cnt_n;
    logic [15:0] trap_pc, trap_pc_n;
    logic        strobe, fetch;

    assign strobe = i_phi2 & ~phi2_q;
    assign fetch  = strobe & i_sync;

    always_comb begin
        state_n      = state;
        last_pc_n    = last_pc;
        repeat_cnt_n = repeat_cnt;
        bus_cnt_n    = bus_cnt;
        instr_cnt_n  = instr_cnt;
        trap_pc_n    = trap_pc;
        if ((state == ARMED || state == RUN) && strobe) begin
            if (bus_cnt != 32'hFFFF_FFFF) begin
                bus_cnt_n = bus_cnt + 32'd1;
            end
            if (fetch) begin
                if (state == ARMED) begin
                    last_pc_n    = i_addr;
                    repeat_cnt_n = 4'd1;
                    instr_cnt_n  = 32'd1;
                    state_n      = RUN;
                end else begin
                    if (instr_cnt != 32'hFFFF_FFFF) begin
                        instr_cnt_n = instr_cnt + 32'd1;
                    end
                    if (i_addr == last_pc) begin
                        if (repeat_cnt != TRAP_LIMIT) begin
                            repeat_cnt_n = repeat_cnt + 4'd1;
                        end
                    end else begin
                        last_pc_n    = i_addr;
                        repeat_cnt_n = 4'd1;
                    end
                end
            end
            // A trap on the same strobe as the timeout takes priority
            if (state == RUN && fetch && repeat_cnt_n == TRAP_LIMIT) begin
                state_n   = (i_addr == SUCCESS_ADDR) ? PASS : FAIL;
                trap_pc_n = i_addr;
            end else if (TIMEOUT_CYCLES != 32'd0 && bus_cnt_n == TIMEOUT_CYCLES) begin
                state_n   = TIMEOUT;
                trap_pc_n = last_pc_n;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ARMED;
            phi2_q     <= 1'b0;
            last_pc    <= 16'h0000;
            repeat_cnt <= 4'd0;
            bus_cnt    <= 32'd0;
            instr_cnt  <= 32'd0;
            trap_pc    <= 16'h0000;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
            o_fail     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_n;
            phi2_q     <= i_phi2;
            last_pc    <= last_pc_n;
            repeat_cnt <= repeat_cnt_n;
            bus_cnt    <= bus_cnt_n;
            instr_cnt  <= instr_cnt_n;
            trap_pc    <= trap_pc_n;
            o_pass     <= (state_n == PASS);
            o_fail     <= (state_n == FAIL);
            o_timeout  <= (state_n == TIMEOUT);
            o_done     <= (state_n == PASS) || (state_n == FAIL) || (state_n == TIMEOUT);
        end
    end

    assign o_trap_pc     = trap_pc;
    assign o_instr_count = instr_cnt;

endmodule
